// File: rtl/mem_bus_master.sv
// Initiator for the shared-bus register memory. Each valid/ready burst request
// becomes address/data phase pairs on Select / RW / DataBus.
module mem_bus_master #(
   parameter int N = 8,
   parameter int M = 2,
   parameter int L = 2
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         ReqValid,
   output logic         ReqReady,
   input  logic         ReqWrite,
   input  logic [M-1:0] ReqAddr,
   input  logic [L-1:0] ReqLen,
   input  logic [N-1:0] WrData,
   input  logic         WrValid,
   output logic         WrReady,
   output logic [N-1:0] RdData,
   output logic         RdValid,
   output logic         Done,
   output logic [M-1:0] Select,
   output logic         RW,
   inout  wire  [N-1:0] DataBus
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;

   state_t         state;
   logic           is_write;
   logic [M-1:0]   addr;
   logic [L-1:0]   remaining;
   logic [N-1:0]   wr_latch;
   logic           drive;

   assign Select  = addr;
   assign DataBus = drive ? wr_latch : {N{1'bz}};

   // NOTE: every register here uses <= so all updates see pre-edge values.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         is_write  <= 1'b0;
         addr      <= '0;
         remaining <= '0;
         wr_latch  <= '0;
         drive     <= 1'b0;
         RW        <= 1'b0;
         ReqReady  <= 1'b1;
         WrReady   <= 1'b0;
         RdData    <= '0;
         RdValid   <= 1'b0;
         Done      <= 1'b0;
      end else begin
         RdValid <= 1'b0;
         Done    <= 1'b0;
         case (state)
            IDLE: begin
               if (ReqValid) begin
                  is_write  <= ReqWrite;
                  addr      <= ReqAddr;
                  remaining <= ReqLen;
                  ReqReady  <= 1'b0;
                  WrReady   <= ReqWrite;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               if (!is_write) begin
                  state <= DATA;
               end else if (WrValid) begin
                  wr_latch <= WrData;
                  WrReady  <= 1'b0;
                  RW       <= 1'b1;
                  drive    <= 1'b1;
                  state    <= DATA;
               end
            end
            DATA: begin
               RW    <= 1'b0;
               drive <= 1'b0;
               // The memory drives the cell it latched at the end of ADDR.
               if (!is_write) begin
                  RdData  <= DataBus;
                  RdValid <= 1'b1;
               end
               if (remaining == '0) begin
                  Done  <= 1'b1;
                  state <= FIN;
               end else begin
                  addr      <= addr + 1'b1;
                  remaining <= remaining - 1'b1;
                  WrReady   <= is_write;
                  state     <= ADDR;
               end
            end
            FIN: begin
               ReqReady <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
